zig_zag_scan: RTL and testbench

Downstream of the quantisation stage. Accepts quantised 8x8 DCT coefficients in raster order (64 per block) and re-emits each block in JPEG zig-zag order for the entropy coder. Uses an internal ping-pong buffer (2 banks x 64 entries), so one bank fills while the other drains; sustains 1 coefficient/clk on both sides with no gaps.

---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/zig_zag_lut.sv | 15 +
 rtl/zig_zag_scan.sv | 155 +++++++++++++++
 tb/tb_zig_zag_scan.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG definitions: coefficient width default, block geometry and the
// zig-zag scan table (zig-zag position -> raster position). The inverse path
// reuses the same table for its own lookups.
package jpeg_pkg;

    // Default width of a quantised, signed DCT coefficient
    localparam int COEF_W_DEFAULT = 12;

    // One 8x8 block holds 64 coefficients; 6 bits index any of them
    localparam int BLOCK_LEN = 64;
    localparam int IDX_W     = 6;

    // Standard JPEG zig-zag order: entry k is the raster (row-major) index of
    // the k-th coefficient emitted by the scan
    localparam logic [IDX_W-1:0] ZZ_TABLE [BLOCK_LEN] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zig_zag_lut.sv
// Combinational zig-zag lookup: converts a position in the zig-zag scan into
// the raster address of the coefficient that belongs there.
module zig_zag_lut
    import jpeg_pkg::*;
(
    input  logic [IDX_W-1:0] zz_idx,
    output logic [IDX_W-1:0] raster_idx
);

    // Pure table lookup, no state
    always_comb begin
        raster_idx = ZZ_TABLE[zz_idx];
    end

endmodule

// File: rtl/zig_zag_scan.sv
// Raster-to-zig-zag reorder stage for 8x8 quantised DCT blocks.
// A two-bank ping-pong buffer lets one block fill while the previous block
// drains, so both sides run at one coefficient per clock with no gaps
// between blocks. The output is a registered valid/ready stage that holds
// its data steady under backpressure.
module zig_zag_scan
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [15:0]       blocks_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

    // Ping-pong storage; contents are never reset because a bank is only
    // read after it has been completely rewritten
    logic [COEF_W-1:0] mem [2][BLOCK_LEN];

    // Write side bookkeeping
    logic             wr_bank;
    logic [IDX_W-1:0] wr_cnt;

    // Read side bookkeeping
    logic             rd_bank;
    logic [IDX_W-1:0] rd_cnt;

    // One flag per bank: set when the bank holds a complete block that has
    // not yet been fully loaded into the output register
    logic [1:0]       full;

    // Handshake and event strobes
    logic             accept;
    logic             wr_done;
    logic             ld;
    logic             rd_done;
    logic             drain;
    logic [IDX_W-1:0] raster_idx;
    logic [COEF_W-1:0] rd_data;

    // The write bank may take data whenever it is not still waiting to drain
    always_comb begin
        in_ready = ce & ~full[wr_bank];
        accept   = in_valid & in_ready;
        wr_done  = accept & (wr_cnt == LAST_IDX);
    end

    // Load the output register when a full bank is available and the output
    // stage is empty or being emptied this cycle; otherwise drop valid once
    // the consumer has taken the pending coefficient
    always_comb begin
        ld      = ce & full[rd_bank] & (~out_valid | out_ready);
        rd_done = ld & (rd_cnt == LAST_IDX);
        drain   = ce & ~ld & out_valid & out_ready;
    end

    // Map the current scan position to the raster address inside the bank
    zig_zag_lut u_lut (
        .zz_idx     (rd_cnt),
        .raster_idx (raster_idx)
    );

    // Combinational read of the draining bank at the zig-zag address
    always_comb begin
        rd_data = mem[rd_bank][raster_idx];
    end

    // Store accepted coefficients at their raster position in the fill bank
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][wr_cnt] <= in_data;
        end
    end

    // Advance the fill pointer; switch banks after the 64th coefficient
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Track which banks hold a complete block; a bank cannot be set and
    // cleared in the same cycle because writing needs it empty and reading
    // needs it full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Advance the drain pointer and release the bank after its last load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else if (ld) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Output register: load the next zig-zag coefficient with its markers,
    // or clear valid after a transfer with nothing new to load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (ld) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_first <= (rd_cnt == '0);
            out_last  <= (rd_cnt == LAST_IDX);
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Count blocks whose final coefficient has been loaded for emission
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_done <= '0;
        end else if (rd_done) begin
            blocks_done <= blocks_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_zig_zag_scan.sv
// Testbench for zig_zag_scan. A queue-fed driver presents coefficients with
// configurable valid/ready/ce behaviour; a negedge monitor rebuilds each
// accepted block and predicts its zig-zag emission from a diagonal walk of
// the 8x8 grid, then scores every output transfer against that prediction.
module tb_zig_zag_scan;

    localparam int W = 12;

    typedef struct {
        logic [W-1:0] d;
        int           k;
    } exp_item_t;

    logic         clk;
    logic         rst;
    logic         ce;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_first;
    logic         out_last;
    logic [15:0]  blocks_done;

    zig_zag_scan #(.COEF_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_first   (out_first),
        .out_last    (out_last),
        .blocks_done (blocks_done)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           zz_ref [64];
    logic [W-1:0] blk [64];
    int           in_count = 0;
    exp_item_t    exp_q [$];
    logic [W-1:0] in_q [$];
    int           blocks_model = 0;

    // Driver controls
    int ce_mode    = 0;
    int valid_pct  = 100;
    int ready_pct  = 100;
    bit in_accepted = 0;
    bit started     = 0;

    // Monitor statistics
    int           cycle = 0;
    int           accept_total = 0;
    int           last_accept_cycle = 0;
    bit           seen_valid = 0;
    int           first_valid_cycle = 0;
    int           last_valid_cycle = 0;
    int           valid_count = 0;
    int           stall_count = 0;
    bit           held_valid = 0;
    logic [W-1:0] held_data;
    logic         held_first;
    logic         held_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue one 64-coefficient block for the driver
    task automatic applyStimulus(input int kind, input int b);
        logic [W-1:0] v;
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       v = W'(b * 64 + i);
                1:       v = W'(12'hFFF - i);
                default: v = W'($urandom);
            endcase
            in_q.push_back(v);
        end
    endtask

    // Bounded wait until every queued coefficient has been accepted, every
    // complete block emitted and no partial block is pending
    task automatic waitIdle(input int max_cycles, input string tag);
        bit done;
        done = 0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            #1;
            done = (in_q.size() == 0) && (exp_q.size() == 0) && (in_count == 0);
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    // Driver: runs just after each rising edge, retires the coefficient that
    // was taken on that edge and presents the next one
    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ce        = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (in_accepted && in_q.size() > 0) begin
                void'(in_q.pop_front());
            end
            case (ce_mode)
                0:       ce = 1'b1;
                1:       ce = ~ce;
                default: ce = ($urandom_range(99) < 80);
            endcase
            out_ready = ($urandom_range(99) < ready_pct);
            if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                in_valid = 1'b1;
                in_data  = in_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end
        end
    end

    // Monitor: samples on the falling edge, i.e. the values the next rising
    // edge will act on
    always @(negedge clk) begin
        exp_item_t e;
        cycle++;
        if (rst) begin
            in_accepted  = 0;
            in_count     = 0;
            exp_q.delete();
            blocks_model = 0;
            held_valid   = 0;
        end else if (started) begin
            in_accepted = in_valid && in_ready;
            if (!ce) begin
                checkOutput("ce_low_in_ready", 32'(in_ready), 32'd0);
            end
            if (in_valid && !in_ready && ce) begin
                stall_count++;
            end
            if (held_valid) begin
                checkOutput("hold_data", 32'(out_data), 32'(held_data));
                checkOutput("hold_first", 32'(out_first), 32'(held_first));
                checkOutput("hold_last", 32'(out_last), 32'(held_last));
            end
            held_valid = out_valid && !(out_ready && ce);
            held_data  = out_data;
            held_first = out_first;
            held_last  = out_last;

            if (in_accepted) begin
                blk[in_count] = in_data;
                in_count++;
                accept_total++;
                last_accept_cycle = cycle;
                if (in_count == 64) begin
                    for (int k = 0; k < 64; k++) begin
                        e.d = blk[zz_ref[k]];
                        e.k = k;
                        exp_q.push_back(e);
                    end
                    in_count = 0;
                end
            end

            if (out_valid) begin
                valid_count++;
                if (!seen_valid) begin
                    first_valid_cycle = cycle;
                end
                seen_valid = 1;
                last_valid_cycle = cycle;
            end

            if (out_valid && out_ready && ce) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(e.d));
                    checkOutput("out_first", 32'(out_first), 32'(e.k == 0));
                    checkOutput("out_last", 32'(out_last), 32'(e.k == 63));
                    if (e.k == 63) begin
                        blocks_model++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int acc0;

        // Zig-zag order as a walk over anti-diagonals: even diagonals run
        // bottom-left to top-right, odd ones top-right to bottom-left
        n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s < 8) ? 0 : s - 7;
            hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_ref[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_ref[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end

        // Asynchronous reset asserted between clock edges
        rst = 1'b0;
        #22;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_first", 32'(out_first), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_blocks_done", 32'(blocks_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1;
        @(negedge clk);
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Single block of raster indices, free-flowing output
        $display("[TB] single block");
        seen_valid = 0;
        applyStimulus(0, 0);
        waitIdle(400, "single_drain");
        checkOutput("single_latency", 32'(first_valid_cycle - last_accept_cycle), 32'd2);
        checkOutput("single_blocks_done", 32'(blocks_done), 32'd1);

        // Three back-to-back blocks, the last one negative
        $display("[TB] streaming");
        seen_valid  = 0;
        valid_count = 0;
        stall_count = 0;
        applyStimulus(0, 0);
        applyStimulus(0, 1);
        applyStimulus(1, 2);
        waitIdle(600, "stream_drain");
        checkOutput("stream_stalls", 32'(stall_count), 32'd0);
        checkOutput("stream_valid_count", 32'(valid_count), 32'd192);
        checkOutput("stream_valid_span", 32'(last_valid_cycle - first_valid_cycle + 1), 32'd192);
        checkOutput("stream_blocks_done", 32'(blocks_done), 32'd4);

        // Backpressure: output stalled, both banks fill, then release
        $display("[TB] backpressure");
        ready_pct = 0;
        acc0 = accept_total;
        applyStimulus(2, 0);
        applyStimulus(2, 1);
        applyStimulus(2, 2);
        repeat (300) @(negedge clk);
        #1;
        checkOutput("bp_accepted", 32'(accept_total - acc0), 32'd128);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_out_first", 32'(out_first), 32'd1);
        if (exp_q.size() > 0) begin
            checkOutput("bp_head_data", 32'(out_data), 32'(exp_q[0].d));
        end else begin
            checkOutput("bp_expect_pending", 32'(exp_q.size()), 32'd128);
        end
        ready_pct = 100;
        waitIdle(800, "bp_drain");
        checkOutput("bp_blocks_done", 32'(blocks_done), 32'(blocks_model));

        // Clock enable toggling every cycle
        $display("[TB] ce gating");
        ce_mode = 1;
        applyStimulus(0, 0);
        waitIdle(800, "ce_drain");
        ce_mode = 0;
        checkOutput("ce_blocks_done", 32'(blocks_done), 32'(blocks_model));

        // Randomized traffic on every handshake and the enable
        $display("[TB] random traffic");
        ce_mode   = 2;
        valid_pct = 70;
        ready_pct = 60;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(2, b);
        end
        waitIdle(5000, "random_drain");
        checkOutput("random_blocks_done", 32'(blocks_done), 32'(blocks_model));
        ce_mode   = 0;
        valid_pct = 100;
        ready_pct = 100;

        // Reset with a partial block in the buffer, then one clean block
        $display("[TB] reset mid-block");
        for (int i = 0; i < 30; i++) begin
            in_q.push_back(W'($urandom));
        end
        n = 0;
        while (in_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("partial_accepted", 32'(in_q.size()), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_blocks_done", 32'(blocks_done), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(2, 0);
        waitIdle(400, "midrst_drain");
        checkOutput("midrst_final_blocks", 32'(blocks_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
